multicycle_alu: RTL and testbench

Parametrised, clocked successor to the single-cycle datapath ALU for the multicycle MIPS core. It keeps the 4-bit operation encoding of the existing ALU operations, registers every result, and adds arithmetic shift-right plus iterative unsigned multiply and divide. Multiply and divide write a HI/LO result pair. The control FSM issues an operation with `start` and waits for `done`. The block sits in the EX stage, in place of the combinational ALU, between the A/B operand registers and ALUOut.

---
 rtl/multicycle_alu_if.sv | 30 +++
 rtl/multicycle_alu.sv | 171 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Issue/result bundle between the multicycle control FSM and the EX-stage ALU.
`timescale 1ns / 1ps

interface multicycle_alu_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start;
  logic [3:0]       ALUCnt;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             illegal;

  modport master (
    output start, ALUCnt, input1, input2, shamt,
    input  result, hi, zero, busy, done, div_zero, illegal
  );

  modport slave (
    input  start, ALUCnt, input1, input2, shamt,
    output result, hi, zero, busy, done, div_zero, illegal
  );
endinterface

// File: rtl/multicycle_alu.sv
// Registered EX-stage ALU with iterative unsigned multiply/divide writing a HI/LO pair.
// Multiply/divide (RUN state, counter, HI path) exist only when ALU_MULDIV_EN is defined.
`timescale 1ns / 1ps

module multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input logic             clk,
  input logic             rst,
  multicycle_alu_if.slave bus
);
  logic [WIDTH-1:0]        a, b;
  logic [SHW-1:0]          sh;
  logic                    shift_big;
  logic signed [WIDTH-1:0] sra;
  logic [WIDTH-1:0]        sc_result;
  logic                    sc_illegal;
  logic [WIDTH-1:0]        result_q;
  logic                    zero_q, done_q, illegal_q;

  assign a         = bus.input1;
  assign b         = bus.input2;
  assign sh        = bus.shamt;
  assign shift_big = 32'(sh) >= WIDTH;
  // Kept as its own signed assignment so the shift stays arithmetic.
  assign sra       = $signed(a) >>> sh;

`ifdef ALU_MULDIV_EN
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic             busy_q, div_zero_q, is_div_q;
  logic [WIDTH-1:0] hi_q, work_hi, work_lo, opb_q;
  logic [CW-1:0]    cnt_q;
  logic             sc_divz, op_long;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
`endif

  always_comb begin
    sc_result  = '0;
    sc_illegal = 1'b0;
`ifdef ALU_MULDIV_EN
    sc_divz    = 1'b0;
    op_long    = 1'b0;
`endif
    case (bus.ALUCnt)
      4'd0: sc_result = a + b;
      4'd1: sc_result = a - b;
      4'd2: sc_result = ~a;
      4'd3: sc_result = shift_big ? '0 : a << sh;
      4'd4: sc_result = shift_big ? '0 : a >> sh;
      4'd5: sc_result = a & b;
      4'd6: sc_result = a | b;
      4'd7: sc_result = {{(WIDTH-1){1'b0}}, a < b};
      4'd8: sc_result = shift_big ? {WIDTH{a[WIDTH-1]}} : sra;
`ifdef ALU_MULDIV_EN
      4'd9: op_long = 1'b1;
      4'd10: begin
        if (b == '0) begin
          sc_result = '1;
          sc_divz   = 1'b1;
        end else begin
          op_long = 1'b1;
        end
      end
`endif
      default: sc_illegal = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // {work_hi, work_lo} is the product/shifted-dividend pair; opb_q is multiplicand or divisor.
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opb_q} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = div_shift >= {1'b0, opb_q};
    if (is_div_q) begin
      nxt_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      nxt_lo = {work_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      opb_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      if (state_q == StRun) begin
        work_hi <= nxt_hi;
        work_lo <= nxt_lo;
        cnt_q   <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_q  <= StIdle;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          result_q <= nxt_lo;
          hi_q     <= nxt_hi;
          zero_q   <= (nxt_lo == '0);
        end
      end else if (bus.start) begin
        div_zero_q <= 1'b0;
        illegal_q  <= 1'b0;
        if (op_long) begin
          state_q  <= StRun;
          busy_q   <= 1'b1;
          is_div_q <= (bus.ALUCnt == 4'd10);
          work_hi  <= '0;
          work_lo  <= (bus.ALUCnt == 4'd10) ? a : b;
          opb_q    <= (bus.ALUCnt == 4'd10) ? b : a;
          cnt_q    <= CW'(WIDTH);
        end else begin
          result_q  <= sc_result;
          zero_q    <= (sc_result == '0);
          done_q    <= 1'b1;
          illegal_q <= sc_illegal;
          if (sc_divz) begin
            hi_q       <= a;
            div_zero_q <= 1'b1;
          end
        end
      end
`else
      if (bus.start) begin
        result_q  <= sc_result;
        zero_q    <= (sc_result == '0);
        done_q    <= 1'b1;
        illegal_q <= sc_illegal;
      end
`endif
    end
  end

  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
`ifdef ALU_MULDIV_EN
  assign bus.hi       = hi_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = div_zero_q;
`else
  assign bus.hi       = '0;
  assign bus.busy     = 1'b0;
  assign bus.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed table, multicycle corner sequences and
// randomized ops against a plain-arithmetic reference model (honours ALU_MULDIV_EN).
`timescale 1ns / 1ps

module tb_multicycle_alu;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] model_hi = '0;

  multicycle_alu_if #(.WIDTH(32), .SHW(5)) bus ();

  multicycle_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic hw,
                                 output logic [31:0] h, output logic ill, output logic dz,
                                 output logic lng);
    logic [63:0]        p;
    logic signed [31:0] sa;
    r = '0; hw = 1'b0; h = '0; ill = 1'b0; dz = 1'b0; lng = 1'b0;
    sa = a;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = ~a;
      4'd3: r = a << sh;
      4'd4: r = a >> sh;
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: begin
        sa = sa >>> sh;
        r  = sa;
      end
`ifdef ALU_MULDIV_EN
      4'd9: begin
        p   = {32'd0, a} * {32'd0, b};
        r   = p[31:0];
        h   = p[63:32];
        hw  = 1'b1;
        lng = 1'b1;
      end
      4'd10: begin
        hw = 1'b1;
        if (b == 0) begin
          r  = 32'hFFFF_FFFF;
          h  = a;
          dz = 1'b1;
        end else begin
          r   = a / b;
          h   = a % b;
          lng = 1'b1;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op, scramble the operand inputs while it runs, then compare against the model.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] er, eh;
    logic        hw, ei, ed, el;
    int          lat;
    ref_op(op, a, b, sh, er, hw, eh, ei, ed, el);
    if (hw) model_hi = eh;
    bus.ALUCnt = op; bus.input1 = a; bus.input2 = b; bus.shamt = sh; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.input1 = $urandom; bus.input2 = $urandom; bus.shamt = 5'($urandom);
    lat = 0;
    while (!bus.done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), el ? 64'd32 : 64'd0);
    check({nm, "_done"},    64'(bus.done),     64'd1);
    check({nm, "_result"},  64'(bus.result),   64'(er));
    check({nm, "_hi"},      64'(bus.hi),       64'(model_hi));
    check({nm, "_zero"},    64'(bus.zero),     64'(er == 0));
    check({nm, "_illegal"}, 64'(bus.illegal),  64'(ei));
    check({nm, "_divzero"}, 64'(bus.div_zero), 64'(ed));
    check({nm, "_busy"},    64'(bus.busy),     64'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    int          lat, busy_cnt, ndone;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    clk = 1'b0; rst = 1'b0;
    bus.start = 1'b0; bus.ALUCnt = '0; bus.input1 = '0; bus.input2 = '0; bus.shamt = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_result",  64'(bus.result),   64'd0);
    check("rst_hi",      64'(bus.hi),       64'd0);
    check("rst_zero",    64'(bus.zero),     64'd1);
    check("rst_busy",    64'(bus.busy),     64'd0);
    check("rst_done",    64'(bus.done),     64'd0);
    check("rst_divzero", 64'(bus.div_zero), 64'd0);
    check("rst_illegal", 64'(bus.illegal),  64'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0});
    vecs.push_back('{4'd1,  32'd5,         32'd7,         5'd0,  32'hFFFF_FFFE, 1'b0});
    vecs.push_back('{4'd2,  32'd0,         32'd9,         5'd0,  32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd3,  32'd1,         32'd0,         5'd31, 32'h8000_0000, 1'b0});
    vecs.push_back('{4'd4,  32'h8000_0000, 32'd0,         5'd4,  32'h0800_0000, 1'b0});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'd0,         5'd4,  32'hF800_0000, 1'b0});
    vecs.push_back('{4'd12, 32'd3,         32'd4,         5'd0,  32'd0,         1'b1});
    vecs.push_back('{4'd5,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0});
    vecs.push_back('{4'd6,  32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0});
    vecs.push_back('{4'd7,  32'd3,         32'd5,         5'd0,  32'd1,         1'b0});
    vecs.push_back('{4'd7,  32'd5,         32'd3,         5'd0,  32'd0,         1'b0});
    vecs.push_back('{4'd7,  32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0});
    vecs.push_back('{4'd8,  32'h4000_0000, 32'd0,         5'd31, 32'd0,         1'b0});
    vecs.push_back('{4'd8,  32'h8000_0000, 32'd0,         5'd31, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{4'd15, 32'd1,         32'd1,         5'd1,  32'd0,         1'b1});
    vecs.push_back('{4'd0,  32'd20,        32'd22,        5'd0,  32'd42,        1'b0});

    // Back-to-back: start stays high, one result per cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      bus.ALUCnt = vecs[i].op; bus.input1 = vecs[i].a; bus.input2 = vecs[i].b;
      bus.shamt = vecs[i].sh; bus.start = 1'b1;
      @(posedge clk); #1;
      check($sformatf("vec%0d_result", i),  64'(bus.result),  64'(vecs[i].res));
      check($sformatf("vec%0d_zero", i),    64'(bus.zero),    64'(vecs[i].res == 0));
      check($sformatf("vec%0d_done", i),    64'(bus.done),    64'd1);
      check($sformatf("vec%0d_illegal", i), 64'(bus.illegal), 64'(vecs[i].ill));
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done),   64'd0);
    check("hold",       64'(bus.result), 64'd42);

    // Asynchronous reset in the middle of a cycle.
    run_op("add_pre_rst", 4'd0, 32'd1, 32'd2, 5'd0);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_zero",   64'(bus.zero),   64'd1);
    check("mid_rst_done",   64'(bus.done),   64'd0);
    #2 rst = 1'b0;
    model_hi = '0;
    @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
    // Multiply with a stray start while busy.
    bus.ALUCnt = 4'd9; bus.input1 = 32'hFFFF_FFFF; bus.input2 = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!bus.done && lat < 64) begin
      if (bus.busy) busy_cnt++;
      bus.start = (lat == 10); bus.ALUCnt = 4'd0; bus.input1 = 32'd1; bus.input2 = 32'd1;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("mul_latency", 64'(lat),         64'd32);
    check("mul_busy_cyc", 64'(busy_cnt),   64'd32);
    check("mul_result",  64'(bus.result),  64'h0000_0001);
    check("mul_hi",      64'(bus.hi),      64'hFFFF_FFFE);
    check("mul_zero",    64'(bus.zero),    64'd0);
    check("mul_busy",    64'(bus.busy),    64'd0);
    model_hi = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    check("mul_done_pulse", 64'(bus.done),   64'd0);
    check("mul_hold",       64'(bus.result), 64'd1);

    run_op("div_100_7", 4'd10, 32'd100, 32'd7, 5'd0);
    check("div_q", 64'(bus.result), 64'd14);
    check("div_r", 64'(bus.hi),     64'd2);
    run_op("div_9_0", 4'd10, 32'd9, 32'd0, 5'd0);
    check("dz_result", 64'(bus.result),   64'hFFFF_FFFF);
    check("dz_hi",     64'(bus.hi),       64'd9);
    check("dz_flag",   64'(bus.div_zero), 64'd1);
    run_op("add_clr_dz", 4'd0, 32'd4, 32'd5, 5'd0);
    check("dz_cleared", 64'(bus.div_zero), 64'd0);

    // Reset during RUN aborts the multiply with no done.
    bus.ALUCnt = 4'd9; bus.input1 = 32'd1234; bus.input2 = 32'd5678; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi",   64'(bus.hi),   64'd0);
    #2 rst = 1'b0;
    model_hi = '0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
`else
    run_op("op9_undef", 4'd9, 32'd6, 32'd7, 5'd0);
    check("op9_illegal", 64'(bus.illegal), 64'd1);
    check("op9_result",  64'(bus.result),  64'd0);
    check("op9_busy",    64'(bus.busy),    64'd0);
    ndone = 0; lat = 0; busy_cnt = 0;
`endif

    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
